song_reader_poly: RTL and testbench
===================================

# song_reader_poly

Parametrised successor of the three-voice song reader. It walks a song stored in an external synchronous ROM and dispatches note entries to the lowest-index free voice among `NUM_VOICES` note players. Rest (time-advance) entries are timed by an external `beat` strobe rather than by a voice's completion. It sits between the song ROM and the bank of note players, under control of the top-level play/song-select logic.

## Interface
Parameters:
- `NUM_VOICES`, 3: number of note players served (1..8)
- `SONG_SEL_WIDTH`, 2: song select width; upper ROM address bits
- `NOTE_ADDR_WIDTH`, 7: entries per song = 2^`NOTE_ADDR_WIDTH`
- `NOTE_WIDTH`, 6: note code width
- `DURATION_WIDTH`, 6: duration / rest-length width
- `META_WIDTH`, 3: metadata field width; ignored by this block
- `ROM_LATENCY`, 1: cycles from `rom_addr` to valid `rom_data` (≥1)

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `play`  in  1  level; high = run, low = pause
- `song`  in  `SONG_SEL_WIDTH`  song select
- `beat`  in  1  one-cycle tick that decrements rest counters
- `note_done`  in  `NUM_VOICES`  per-voice one-cycle "finished" pulse
- `rom_addr`  out  `SONG_SEL_WIDTH+NOTE_ADDR_WIDTH`  {song_q, entry index}
- `rom_data`  in  1+`NOTE_WIDTH`+`DURATION_WIDTH`+`META_WIDTH`  ROM word: MSB = type (0 note, 1 rest), then note, then duration, then meta
- `note`  out  `NUM_VOICES*NOTE_WIDTH`  packed per-voice note; voice i at [i*NOTE_WIDTH +: NOTE_WIDTH]
- `duration`  out  `NUM_VOICES*DURATION_WIDTH`  packed per-voice duration
- `new_note`  out  `NUM_VOICES`  one-hot one-cycle load strobe
- `song_done`  out  1  one-cycle pulse after the last entry of a song
- `busy`  out  1  high in every state except PAUSED

## Operation
- States: PAUSED, FETCH, DECODE, DISPATCH, STALL, REST, ADVANCE.
- PAUSED: on `play`, go to FETCH. `song_q` is loaded from `song` whenever `song` differs from `song_q`.
- FETCH: hold `rom_addr` for `ROM_LATENCY` cycles (latency counter), then go to DECODE.
- DECODE: sample `rom_data`.
  - Type 0, any voice free: load the note/duration register of the lowest-index free voice, then go to DISPATCH.
  - Type 0, no voice free: go to STALL.
  - Type 1, duration 0: go to ADVANCE.
  - Type 1, duration nonzero: load the rest counter with duration, then go to REST.
- DISPATCH: assert `new_note[i]` for the selected voice; clear `free[i]`; go to ADVANCE.
- STALL: wait for any `free` bit. The first cycle one is seen, load the lowest free voice, then go to DISPATCH.
- REST: each `beat` decrements the counter. At 1 and `beat`, go to ADVANCE.
- ADVANCE: increment the entry index and go to FETCH.
  - If the index was all-ones: pulse `song_done`, set the index to 0, go to PAUSED.
- `free[i]`: reset value 1. Set by `note_done[i]`. Cleared by `new_note[i]`; clear wins when both occur in the same cycle.
- `play` low in FETCH/DECODE/STALL/REST/ADVANCE: next state PAUSED, index retained, rest counter discarded. Resume re-fetches the same entry; a rest restarts at full length.
- DISPATCH always completes its pulse before honouring `play` low.
- `song` change while not PAUSED: index set to 0, `song_q` updated, next state FETCH (if `play`) else PAUSED. No `song_done` pulse. Takes priority over every other transition except reset.
- Note/duration registers hold their value until the next `new_note` to that voice.

## Timing
- Reset values: state PAUSED, index 0, `song_q` = 0, all `free` = 1, `note`/`duration` = 0, `new_note` = 0, `song_done` = 0, `busy` = 0.
- With `ROM_LATENCY` = 1 and a free voice: `play` rises at t0.
  - FETCH at t1, DECODE at t2.
  - `new_note` high at t3, with `note`/`duration` already valid at t3.
  - ADVANCE at t4; next FETCH at t5.
  - Throughput is one note per 4 cycles, or 3+`ROM_LATENCY` in general.
- `note_done` arriving in the STALL cycle is usable that cycle through the combinational free-next path: dispatch occurs one cycle later.
- `song_done` is registered and coincides with the first PAUSED cycle.
- `beat` is ignored outside REST.

## Structure
- Package `song_pkg`:
  - state enum
  - ROM-word field offsets as functions of the width parameters
  - type encodings `TYPE_NOTE` / `TYPE_REST`
- Sub-module `voice_allocator`:
  - holds the `free` flags
  - lowest-index priority encoder
  - outputs `any_free` and a one-hot `grant`; accepts `commit`
- Top module: FSM, index/latency/rest counters, per-voice output registers.

## Test plan
- Three consecutive note entries (notes 5, 9, 12; duration 8), `NUM_VOICES` = 3 → `new_note` = 001, 010, 100 at 4-cycle spacing; `note` fields = 5, 9, 12.
- Fourth note with no `note_done` → STALL. Then `note_done` = 010 → `new_note` = 010 one cycle later with the fourth note.
- Rest entry, duration 3, `beat` every 5 cycles → ADVANCE follows the third beat. Rest entry with duration 0 → DECODE goes straight to ADVANCE.
- `play` dropped mid-REST after 1 beat, then raised → same entry re-fetched; 3 full beats required.
- Run to index 127 (`NOTE_ADDR_WIDTH` = 7) → single `song_done` pulse, `rom_addr` index returns to 0, `busy` low.
- `song` changed 2→1 mid-song with `play` high → next `rom_addr` = {1, 0}, no `song_done`. Also assert `reset` mid-STALL → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/song_pkg.sv
// song_pkg: shared state encoding and ROM-word layout helpers
// for the polyphonic song reader.
package song_pkg;

    typedef enum logic [2:0] {
        S_PAUSED,
        S_FETCH,
        S_DECODE,
        S_DISPATCH,
        S_STALL,
        S_REST,
        S_ADVANCE
    } state_e;

    localparam logic TYPE_NOTE = 1'b0;
    localparam logic TYPE_REST = 1'b1;

    // ROM word, MSB first: type | note | duration | meta
    function automatic int dur_lsb(input int meta_w);
        return meta_w;
    endfunction

    function automatic int note_lsb(input int dur_w, input int meta_w);
        return dur_w + meta_w;
    endfunction

    function automatic int type_bit(input int note_w, input int dur_w,
                                    input int meta_w);
        return note_w + dur_w + meta_w;
    endfunction

endpackage

// File: rtl/song_reader_poly_alloc.sv
// voice_allocator: per-voice free flags and a lowest-index grant
// computed from the free-next value so same-cycle releases count.
module voice_allocator #(
    parameter int NUM_VOICES = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [NUM_VOICES-1:0] note_done_i,
    input  logic [NUM_VOICES-1:0] commit_i,
    output logic                  any_free_o,
    output logic [NUM_VOICES-1:0] grant_o
);

    logic [NUM_VOICES-1:0] free_q;
    logic [NUM_VOICES-1:0] free_d;

    // commit clears after note_done sets, so a clear wins
    assign free_d     = (free_q | note_done_i) & ~commit_i;
    assign grant_o    = free_d & (~free_d + 1'b1);
    assign any_free_o = |free_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            free_q <= '1;
        end else begin
            free_q <= free_d;
        end
    end

endmodule

// File: rtl/song_reader_poly.sv
// song_reader_poly: walks a song in a synchronous ROM and hands note
// entries to the lowest free voice; rests are timed by beat strobes.
module song_reader_poly
    import song_pkg::*;
#(
    parameter int NUM_VOICES      = 3,
    parameter int SONG_SEL_WIDTH  = 2,
    parameter int NOTE_ADDR_WIDTH = 7,
    parameter int NOTE_WIDTH      = 6,
    parameter int DURATION_WIDTH  = 6,
    parameter int META_WIDTH      = 3,
    parameter int ROM_LATENCY     = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 play,
    input  logic [SONG_SEL_WIDTH-1:0]            song,
    input  logic                                 beat,
    input  logic [NUM_VOICES-1:0]                note_done,
    output logic [SONG_SEL_WIDTH+NOTE_ADDR_WIDTH-1:0] rom_addr,
    input  logic [NOTE_WIDTH+DURATION_WIDTH+META_WIDTH:0] rom_data,
    output logic [NUM_VOICES*NOTE_WIDTH-1:0]     note,
    output logic [NUM_VOICES*DURATION_WIDTH-1:0] duration,
    output logic [NUM_VOICES-1:0]                new_note,
    output logic                                 song_done,
    output logic                                 busy
);

    localparam int NW = NOTE_WIDTH;
    localparam int DW = DURATION_WIDTH;
    localparam int DUR_LSB = dur_lsb(META_WIDTH);
    localparam int NOTE_LSB = note_lsb(DW, META_WIDTH);
    localparam int TYPE_BIT = type_bit(NW, DW, META_WIDTH);
    localparam int LW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
    localparam logic [LW-1:0] LAT_MAX = LW'(ROM_LATENCY - 1);

    state_e                        state_q;
    logic [NOTE_ADDR_WIDTH-1:0]    idx_q;
    logic [SONG_SEL_WIDTH-1:0]     song_q;
    logic [LW-1:0]                 lat_q;
    logic [DW-1:0]                 rest_q;
    logic [NUM_VOICES*NW-1:0]      note_q;
    logic [NUM_VOICES*DW-1:0]      dur_q;
    logic [NUM_VOICES-1:0]         new_note_q;
    logic                          song_done_q;

    logic                  w_type;
    logic [NW-1:0]         w_note;
    logic [DW-1:0]         w_dur;
    logic                  unused_meta;
    logic                  any_free;
    logic [NUM_VOICES-1:0] grant;
    logic                  song_chg;
    logic                  stop;
    logic                  load;

    assign w_type      = rom_data[TYPE_BIT];
    assign w_note      = rom_data[NOTE_LSB +: NW];
    assign w_dur       = rom_data[DUR_LSB +: DW];
    assign unused_meta = ^rom_data[META_WIDTH-1:0];

    assign song_chg = (state_q != S_PAUSED) && (song != song_q);
    // DISPATCH is exempt so an issued strobe always reaches ADVANCE
    assign stop = !play && (state_q != S_PAUSED)
               && (state_q != S_DISPATCH);
    assign load = !song_chg && !stop && any_free
               && ((state_q == S_DECODE && w_type == TYPE_NOTE)
                   || state_q == S_STALL);

    voice_allocator #(
        .NUM_VOICES(NUM_VOICES)
    ) u_alloc (
        .clk_i      (clk),
        .reset_i    (reset),
        .note_done_i(note_done),
        .commit_i   (new_note_q),
        .any_free_o (any_free),
        .grant_o    (grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_PAUSED;
            idx_q       <= '0;
            song_q      <= '0;
            lat_q       <= '0;
            rest_q      <= '0;
            song_done_q <= 1'b0;
        end else begin
            song_done_q <= 1'b0;
            if (song_chg) begin
                song_q  <= song;
                idx_q   <= '0;
                lat_q   <= '0;
                state_q <= play ? S_FETCH : S_PAUSED;
            end else if (stop) begin
                lat_q   <= '0;
                state_q <= S_PAUSED;
            end else begin
                unique case (state_q)
                    S_PAUSED: begin
                        if (song != song_q) song_q <= song;
                        if (play) begin
                            lat_q   <= '0;
                            state_q <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        if (lat_q == LAT_MAX) begin
                            lat_q   <= '0;
                            state_q <= S_DECODE;
                        end else begin
                            lat_q <= lat_q + 1'b1;
                        end
                    end
                    S_DECODE: begin
                        unique case (w_type)
                            TYPE_NOTE: state_q <= any_free ? S_DISPATCH
                                                           : S_STALL;
                            TYPE_REST: begin
                                rest_q  <= w_dur;
                                state_q <= (w_dur == '0) ? S_ADVANCE
                                                         : S_REST;
                            end
                        endcase
                    end
                    S_DISPATCH: state_q <= S_ADVANCE;
                    S_STALL: if (any_free) state_q <= S_DISPATCH;
                    S_REST: begin
                        if (beat) begin
                            if (rest_q == DW'(1)) state_q <= S_ADVANCE;
                            else rest_q <= rest_q - 1'b1;
                        end
                    end
                    S_ADVANCE: begin
                        if (&idx_q) begin
                            idx_q       <= '0;
                            song_done_q <= 1'b1;
                            state_q     <= S_PAUSED;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                    default: state_q <= S_PAUSED;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            note_q     <= '0;
            dur_q      <= '0;
            new_note_q <= '0;
        end else begin
            new_note_q <= load ? grant : '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (load && grant[i]) begin
                    note_q[i*NW +: NW] <= w_note;
                    dur_q[i*DW +: DW]  <= w_dur;
                end
            end
        end
    end

    assign rom_addr  = {song_q, idx_q};
    assign note      = note_q;
    assign duration  = dur_q;
    assign new_note  = new_note_q;
    assign song_done = song_done_q;
    assign busy      = (state_q != S_PAUSED);

endmodule

// File: tb/tb_song_reader_poly.sv
// tb_song_reader_poly: entry-level reference model of the song reader
// driven with directed scenarios and randomized songs/releases/beats.
module tb_song_reader_poly;

    localparam int NV  = 3;
    localparam int SW  = 2;
    localparam int NAW = 7;
    localparam int NW  = 6;
    localparam int DW  = 6;
    localparam int MW  = 3;
    localparam int LAT = 1;
    localparam int AW  = SW + NAW;
    localparam int WW  = 1 + NW + DW + MW;
    localparam int LIM = 2000;

    logic          clk;
    logic          reset;
    logic          play;
    logic [SW-1:0] song;
    logic          beat;
    logic [NV-1:0] note_done;
    logic [AW-1:0] rom_addr;
    logic [WW-1:0] rom_data;
    logic [NV*NW-1:0] note;
    logic [NV*DW-1:0] duration;
    logic [NV-1:0] new_note;
    logic          song_done;
    logic          busy;

    logic [WW-1:0] rom [0:(1<<AW)-1];

    logic [NV-1:0]  m_free;
    logic [NW-1:0]  m_note [NV];
    logic [DW-1:0]  m_dur [NV];
    logic [SW-1:0]  m_song;
    logic [NAW-1:0] m_idx;
    bit             sd_pending;
    bit             rand_nd;
    int             beat_period;
    bit             nd_force_en;
    logic [NV-1:0]  nd_force;
    int             cyc_cnt;
    int             n_cmp;
    int             n_err;

    song_reader_poly #(
        .NUM_VOICES(NV), .SONG_SEL_WIDTH(SW), .NOTE_ADDR_WIDTH(NAW),
        .NOTE_WIDTH(NW), .DURATION_WIDTH(DW), .META_WIDTH(MW),
        .ROM_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .play(play), .song(song),
        .beat(beat), .note_done(note_done), .rom_addr(rom_addr),
        .rom_data(rom_data), .note(note), .duration(duration),
        .new_note(new_note), .song_done(song_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NV*NW-1:0] exp_notes();
        logic [NV*NW-1:0] v;
        for (int i = 0; i < NV; i++) v[i*NW +: NW] = m_note[i];
        return v;
    endfunction

    function automatic logic [NV*DW-1:0] exp_durs();
        logic [NV*DW-1:0] v;
        for (int i = 0; i < NV; i++) v[i*DW +: DW] = m_dur[i];
        return v;
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < NV; i++) if (m_free[i]) return i;
        return 0;
    endfunction

    function automatic logic [WW-1:0] mk(input logic t, input int n,
                                         input int d);
        return {t, NW'(n), DW'(d), MW'($urandom)};
    endfunction

    // check this cycle's outputs, then drive this cycle's inputs
    task automatic cyc(input logic [NV-1:0] exp_nn, input logic exp_busy,
                       input logic exp_sd, input string tag,
                       output logic b);
        logic [NV-1:0] nd;
        chk({tag, ":new_note"}, 64'(new_note), 64'(exp_nn));
        chk({tag, ":busy"}, 64'(busy), 64'(exp_busy));
        chk({tag, ":song_done"}, 64'(song_done), 64'(exp_sd));
        chk({tag, ":rom_addr"}, 64'(rom_addr), 64'({m_song, m_idx}));
        chk({tag, ":note"}, 64'(note), 64'(exp_notes()));
        chk({tag, ":duration"}, 64'(duration), 64'(exp_durs()));
        if (nd_force_en) nd = nd_force;
        else if (rand_nd && $urandom_range(0, 3) == 0) nd = NV'($urandom);
        else nd = '0;
        if (beat_period == 0) b = ($urandom_range(0, 2) == 0);
        else b = (cyc_cnt % beat_period == 0);
        note_done = nd;
        beat = b;
        m_free = (m_free | nd) & ~exp_nn;
        cyc_cnt++;
        @(posedge clk);
        #1;
    endtask

    // mode 1: drop play after the first beat of a rest
    // mode 2: assert reset on the third stall cycle
    task automatic run_entry(input int mode);
        logic [WW-1:0] w;
        logic [DW-1:0] d;
        logic b;
        int k;
        int beats;
        int v;
        w = rom[{m_song, m_idx}];
        d = w[DW+MW-1 -: DW];
        for (int i = 0; i < LAT; i++) cyc('0, 1'b1, 1'b0, "fetch", b);
        cyc('0, 1'b1, 1'b0, "decode", b);
        if (w[WW-1] == 1'b0) begin
            k = 0;
            while (m_free == '0 && k < LIM) begin
                if (mode == 2 && k == 2) begin
                    reset = 1'b1;
                    cyc('0, 1'b1, 1'b0, "stall_rst", b);
                    reset = 1'b0;
                    return;
                end
                if (!rand_nd) begin
                    nd_force_en = (k == 3);
                    nd_force = NV'(2);
                end else begin
                    nd_force_en = (k >= 30);
                    nd_force = NV'(1);
                end
                cyc('0, 1'b1, 1'b0, "stall", b);
                nd_force_en = 1'b0;
                k++;
            end
            chk("stall_bound", 64'(k < LIM), 64'(1));
            v = lowest_free();
            m_note[v] = w[WW-2 -: NW];
            m_dur[v] = d;
            cyc(NV'(1 << v), 1'b1, 1'b0, "dispatch", b);
        end else begin
            beats = 0;
            k = 0;
            while (beats < int'(d) && k < LIM) begin
                cyc('0, 1'b1, 1'b0, "rest", b);
                k++;
                if (b) beats++;
                if (mode == 1 && beats == 1) begin
                    play = 1'b0;
                    cyc('0, 1'b1, 1'b0, "rest_pause", b);
                    return;
                end
            end
            chk("rest_bound", 64'(k < LIM), 64'(1));
        end
        cyc('0, 1'b1, 1'b0, "advance", b);
        if (&m_idx) begin
            m_idx = '0;
            sd_pending = 1'b1;
        end else begin
            m_idx = m_idx + 1'b1;
        end
    endtask

    initial begin
        logic b;
        n_cmp = 0;
        n_err = 0;
        cyc_cnt = 0;
        rand_nd = 1'b0;
        beat_period = 5;
        nd_force_en = 1'b0;
        nd_force = '0;
        sd_pending = 1'b0;
        reset = 1'b1;
        play = 1'b0;
        song = '0;
        beat = 1'b0;
        note_done = '0;
        m_free = '1;
        m_song = '0;
        m_idx = '0;
        for (int i = 0; i < NV; i++) begin
            m_note[i] = '0;
            m_dur[i] = '0;
        end
        for (int a = 0; a < (1 << AW); a++) begin
            if ($urandom_range(0, 3) == 0)
                rom[a] = mk(1'b1, $urandom, $urandom_range(0, 4));
            else
                rom[a] = mk(1'b0, $urandom, $urandom);
        end
        rom[0] = mk(1'b0, 5, 8);
        rom[1] = mk(1'b0, 9, 8);
        rom[2] = mk(1'b0, 12, 8);
        rom[3] = mk(1'b0, 20, 8);
        rom[4] = mk(1'b1, 0, 3);
        rom[5] = mk(1'b1, 0, 0);
        rom[6] = mk(1'b1, 0, 3);
        for (int a = 0; a < 4; a++)
            rom[(1 << NAW) + a] = mk(1'b0, 40 + a, 10 + a);

        repeat (2) @(posedge clk);
        #1;
        chk("rst:busy", 64'(busy), 64'(0));
        chk("rst:new_note", 64'(new_note), 64'(0));
        chk("rst:song_done", 64'(song_done), 64'(0));
        chk("rst:note", 64'(note), 64'(0));
        chk("rst:duration", 64'(duration), 64'(0));
        chk("rst:rom_addr", 64'(rom_addr), 64'(0));
        reset = 1'b0;
        cyc('0, 1'b0, 1'b0, "idle", b);
        play = 1'b1;
        cyc('0, 1'b0, 1'b0, "play_rise", b);

        for (int e = 0; e < 6; e++) run_entry(0);
        run_entry(1);
        cyc('0, 1'b0, 1'b0, "paused", b);
        play = 1'b1;
        cyc('0, 1'b0, 1'b0, "resume", b);
        run_entry(0);

        rand_nd = 1'b1;
        beat_period = 0;
        while (!sd_pending) run_entry(0);
        play = 1'b0;
        sd_pending = 1'b0;
        cyc('0, 1'b0, 1'b1, "song_done", b);
        cyc('0, 1'b0, 1'b0, "after_done", b);

        song = SW'(2);
        cyc('0, 1'b0, 1'b0, "sel2", b);
        m_song = SW'(2);
        play = 1'b1;
        cyc('0, 1'b0, 1'b0, "start2", b);
        for (int e = 0; e < 4; e++) run_entry(0);
        song = SW'(1);
        nd_force_en = 1'b1;
        nd_force = '1;
        cyc('0, 1'b1, 1'b0, "fetch_chg", b);
        nd_force_en = 1'b0;
        m_song = SW'(1);
        m_idx = '0;
        rand_nd = 1'b0;
        beat_period = 5;
        for (int e = 0; e < 3; e++) run_entry(0);
        run_entry(2);

        song = '0;
        play = 1'b0;
        m_free = '1;
        m_song = '0;
        m_idx = '0;
        for (int i = 0; i < NV; i++) begin
            m_note[i] = '0;
            m_dur[i] = '0;
        end
        cyc('0, 1'b0, 1'b0, "post_reset", b);
        cyc('0, 1'b0, 1'b0, "post_reset2", b);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
